sd_cmd_sequencer: RTL and testbench
===================================

SD_CMD_SEQUENCER -- requirements
Module: sd_cmd_sequencer

Interface
REQ-001 Parameter NCR_MAX, default 8: the maximum number of 0xFF poll bytes sent while waiting for R1; legal range 1..255.
REQ-002 Parameter PRE_BYTES, default 1: the number of 0xFF bytes sent with cs_n low before the command; legal range 0..15.
REQ-003 clk  in  1  single clock domain for the whole block.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 cmd_valid  in  1  host command request.
REQ-006 cmd_ready  out  1  high when in IDLE; a command is accepted on a cycle where cmd_valid and cmd_ready are both high.
REQ-007 cmd_idx  in  6  SD command index.
REQ-008 cmd_arg  in  32  command argument.
REQ-009 resp_valid  out  1  one-cycle pulse marking the end of a transaction.
REQ-010 resp_r1  out  8  captured R1 byte; reads 0xFF on timeout.
REQ-011 resp_timeout  out  1  qualifies resp_valid: no R1 was received within NCR_MAX bytes.
REQ-012 cs_n  out  1  SD chip select, active low.
REQ-013 spi_start  out  1  one-cycle byte-start strobe to the SPI byte engine.
REQ-014 spi_tx  out  8  byte to send; valid whenever spi_start is high.
REQ-015 spi_ready  in  1  byte engine idle/done; high from reset; falls the cycle after an accepted start.
REQ-016 spi_rx  in  8  received byte; valid when spi_ready rises.

Function
REQ-017 States SHALL be: IDLE, PRE, CMD, POLL, TRAIL, DONE.
REQ-018 On acceptance, cmd_idx and cmd_arg SHALL be latched, cs_n driven low, and the state SHALL move to PRE, or to CMD if PRE_BYTES=0.
REQ-019 Byte issue SHALL follow the same sequence in every state:
- assert spi_start for exactly one cycle, and only when spi_ready=1;
- ignore spi_ready on the following cycle;
- treat the byte as complete on the first later cycle with spi_ready=1.
REQ-020 The next byte's spi_start SHALL come no earlier than the cycle after completion, and never while spi_ready=0.
REQ-021 PRE SHALL send PRE_BYTES bytes of 0xFF, then go to CMD.
REQ-022 CMD SHALL send 6 bytes, then go to POLL:
- {2'b01, idx};
- arg[31:24], arg[23:16], arg[15:8], arg[7:0];
- {crc7, 1'b1}.
REQ-023 crc7 SHALL use polynomial x^7+x^3+1 with initial value 0, computed MSB-first over the first 5 command bytes, and SHALL be ready before byte 6 is issued.
REQ-024 POLL SHALL send 0xFF bytes and evaluate spi_rx at each completion:
- spi_rx[7]=0: latch resp_r1=spi_rx, clear the timeout flag, go to TRAIL;
- else, if NCR_MAX bytes have been polled: set the timeout flag, set resp_r1=0xFF, go to TRAIL;
- otherwise send the next poll byte.
REQ-025 The poll counter SHALL be 8 bits wide and SHALL be cleared on entry to POLL.
REQ-026 cs_n SHALL go high on the cycle POLL exits; TRAIL SHALL then send one 0xFF byte with cs_n high.
REQ-027 DONE SHALL last one cycle, pulsing resp_valid with resp_r1 and resp_timeout valid, then return to IDLE.
REQ-028 resp_r1 and resp_timeout SHALL hold their values until the next resp_valid.
REQ-029 cmd_ready SHALL be low in every state except IDLE; cmd_valid outside IDLE SHALL be ignored, with no queueing.
REQ-030 A command accepted while spi_ready=0, for example an engine still busy after reset release, SHALL delay the first spi_start until spi_ready=1.
REQ-031 A command SHALL be accepted on the cycle after resp_valid, so back-to-back commands are legal.
REQ-032 spi_tx SHALL equal 0xFF whenever no command byte is being issued.

Reset
REQ-033 Reset values while rst is high: state IDLE, cs_n=1, spi_start=0, spi_tx=0xFF, cmd_ready=1, resp_valid=0, resp_r1=0xFF, resp_timeout=0, all counters 0.
REQ-034 Reset asserted mid-transaction SHALL abort immediately:
- no further spi_start is issued;
- cs_n goes high asynchronously;
- the R1 result is not delivered.

Verification
REQ-035 CMD0, arg 0, card model answers 0x01 on the 2nd poll byte -> spi_tx sequence FF,40,00,00,00,00,95,FF,FF,FF; resp_r1=0x01, resp_timeout=0.
REQ-036 CMD8, arg 0x000001AA -> sixth command byte is 0x87; with model R1=0x01 -> resp_r1=0x01.
REQ-037 Card returns 0xFF forever, NCR_MAX=8 -> exactly 8 poll bytes, then one trailer byte; resp_timeout=1, resp_r1=0xFF.
REQ-038 cmd_valid held high across a whole transaction -> exactly one acceptance per IDLE visit, and the next command starts the cycle after resp_valid.
REQ-039 rst pulsed during the 3rd CMD byte -> cs_n=1, no resp_valid, cmd_ready=1 after release, and a subsequent CMD0 completes correctly.
REQ-040 Byte engine modelled with a variable ready latency of 2..40 cycles -> spi_start never asserted while spi_ready=0, and every spi_start is a single-cycle pulse.

Source files
------------

// File: rtl/sd_cmd_sequencer.sv
// SD-card SPI-mode command sequencer: frames one command (optional preamble, 6 command bytes
// with CRC7), polls for R1, sends a trailer byte with cs_n high and reports the result.
module sd_cmd_sequencer #(
  parameter int unsigned NCR_MAX   = 8,
  parameter int unsigned PRE_BYTES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_idx,
  input  logic [31:0] cmd_arg,
  output logic        resp_valid,
  output logic [7:0]  resp_r1,
  output logic        resp_timeout,
  output logic        cs_n,
  output logic        spi_start,
  output logic [7:0]  spi_tx,
  input  logic        spi_ready,
  input  logic [7:0]  spi_rx
);

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StCmd,
    StPoll,
    StTrail,
    StDone
  } state_e;

  // Per-byte handshake: issue when engine ready, skip one cycle, then wait for ready.
  typedef enum logic [1:0] {
    PhIssue,
    PhSkip,
    PhWait
  } phase_e;

  localparam logic [7:0] NcrMax  = 8'(NCR_MAX);
  localparam logic [3:0] PreLast = 4'(PRE_BYTES - 1);

  function automatic logic [6:0] crc7_update(input logic [6:0] crc, input logic [7:0] data);
    logic [6:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ data[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  state_e      state_q, state_d;
  phase_e      phase_q, phase_d;
  logic [3:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  poll_cnt_q, poll_cnt_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] arg_q, arg_d;
  logic [6:0]  crc_q, crc_d;
  logic        cs_n_q, cs_n_d;
  logic [7:0]  r1_cap_q, r1_cap_d;
  logic        to_cap_q, to_cap_d;
  logic [7:0]  resp_r1_q, resp_r1_d;
  logic        resp_timeout_q, resp_timeout_d;

  logic        byte_done;
  logic [7:0]  cmd_byte;
  logic [7:0]  poll_next;

  always_comb begin
    case (byte_cnt_q)
      4'd0:    cmd_byte = {2'b01, idx_q};
      4'd1:    cmd_byte = arg_q[31:24];
      4'd2:    cmd_byte = arg_q[23:16];
      4'd3:    cmd_byte = arg_q[15:8];
      4'd4:    cmd_byte = arg_q[7:0];
      4'd5:    cmd_byte = {crc_q, 1'b1};
      default: cmd_byte = 8'hFF;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    byte_cnt_d     = byte_cnt_q;
    poll_cnt_d     = poll_cnt_q;
    idx_d          = idx_q;
    arg_d          = arg_q;
    crc_d          = crc_q;
    cs_n_d         = cs_n_q;
    r1_cap_d       = r1_cap_q;
    to_cap_d       = to_cap_q;
    resp_r1_d      = resp_r1_q;
    resp_timeout_d = resp_timeout_q;
    spi_start      = 1'b0;
    spi_tx         = 8'hFF;
    cmd_ready      = 1'b0;
    resp_valid     = 1'b0;
    byte_done      = 1'b0;
    poll_next      = poll_cnt_q + 8'd1;

    if (state_q inside {StPre, StCmd, StPoll, StTrail}) begin
      unique case (phase_q)
        PhIssue: begin
          if (spi_ready) begin
            spi_start = 1'b1;
            phase_d   = PhSkip;
          end
        end
        PhSkip: phase_d = PhWait;
        PhWait: begin
          if (spi_ready) begin
            byte_done = 1'b1;
            phase_d   = PhIssue;
          end
        end
        default: phase_d = PhIssue;
      endcase
    end

    case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          idx_d      = cmd_idx;
          arg_d      = cmd_arg;
          crc_d      = 7'd0;
          cs_n_d     = 1'b0;
          byte_cnt_d = 4'd0;
          phase_d    = PhIssue;
          state_d    = (PRE_BYTES == 0) ? StCmd : StPre;
        end
      end
      StPre: begin
        if (byte_done) begin
          if (byte_cnt_q == PreLast) begin
            byte_cnt_d = 4'd0;
            state_d    = StCmd;
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
          end
        end
      end
      StCmd: begin
        if (spi_start) begin
          spi_tx = cmd_byte;
          // CRC covers bytes 0..4 only; it is complete by the time byte 5 is issued.
          if (byte_cnt_q < 4'd5) crc_d = crc7_update(crc_q, cmd_byte);
        end
        if (byte_done) begin
          if (byte_cnt_q == 4'd5) begin
            byte_cnt_d = 4'd0;
            poll_cnt_d = 8'd0;
            state_d    = StPoll;
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
          end
        end
      end
      StPoll: begin
        if (byte_done) begin
          if (!spi_rx[7]) begin
            r1_cap_d = spi_rx;
            to_cap_d = 1'b0;
            cs_n_d   = 1'b1;
            state_d  = StTrail;
          end else if (poll_next == NcrMax) begin
            r1_cap_d = 8'hFF;
            to_cap_d = 1'b1;
            cs_n_d   = 1'b1;
            state_d  = StTrail;
          end else begin
            poll_cnt_d = poll_next;
          end
        end
      end
      StTrail: begin
        if (byte_done) begin
          // Result registers change only as resp_valid rises, so they hold between reports.
          resp_r1_d      = r1_cap_q;
          resp_timeout_d = to_cap_q;
          state_d        = StDone;
        end
      end
      StDone: begin
        resp_valid = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      phase_q        <= PhIssue;
      byte_cnt_q     <= 4'd0;
      poll_cnt_q     <= 8'd0;
      idx_q          <= 6'd0;
      arg_q          <= 32'd0;
      crc_q          <= 7'd0;
      cs_n_q         <= 1'b1;
      r1_cap_q       <= 8'hFF;
      to_cap_q       <= 1'b0;
      resp_r1_q      <= 8'hFF;
      resp_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      byte_cnt_q     <= byte_cnt_d;
      poll_cnt_q     <= poll_cnt_d;
      idx_q          <= idx_d;
      arg_q          <= arg_d;
      crc_q          <= crc_d;
      cs_n_q         <= cs_n_d;
      r1_cap_q       <= r1_cap_d;
      to_cap_q       <= to_cap_d;
      resp_r1_q      <= resp_r1_d;
      resp_timeout_q <= resp_timeout_d;
    end
  end

  assign cs_n         = cs_n_q;
  assign resp_r1      = resp_r1_q;
  assign resp_timeout = resp_timeout_q;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Scoreboard bench for sd_cmd_sequencer: byte-engine and card model, expected bytes and results
// queued at issue time and popped by a monitor as the DUT produces them.
module tb_sd_cmd_sequencer;

  localparam int NcrMax   = 8;
  localparam int PreBytes = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [5:0]  cmd_idx = 6'd0;
  logic [31:0] cmd_arg = 32'd0;
  logic        resp_valid;
  logic [7:0]  resp_r1;
  logic        resp_timeout;
  logic        cs_n;
  logic        spi_start;
  logic [7:0]  spi_tx;
  logic        spi_ready = 1'b1;
  logic [7:0]  spi_rx = 8'hFF;

  sd_cmd_sequencer #(
    .NCR_MAX  (NcrMax),
    .PRE_BYTES(PreBytes)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_idx     (cmd_idx),
    .cmd_arg     (cmd_arg),
    .resp_valid  (resp_valid),
    .resp_r1     (resp_r1),
    .resp_timeout(resp_timeout),
    .cs_n        (cs_n),
    .spi_start   (spi_start),
    .spi_tx      (spi_tx),
    .spi_ready   (spi_ready),
    .spi_rx      (spi_rx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_tx[$];    // {cs_n, byte}
  logic [8:0] exp_resp[$];  // {timeout, r1}
  int answer_at = 0;
  logic [7:0] card_r1 = 8'h01;
  int lat_min = 2;
  int lat_max = 2;
  int resp_cnt = 0;
  int accept_cnt = 0;
  int start_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Card answers r1 on poll number answer_at (1-based); everything else reads 0xFF.
  function automatic logic [7:0] card_byte(input int idx, input logic cs);
    int p;
    if (cs) return 8'hFF;
    p = idx - PreBytes - 6 + 1;
    if (p >= 1 && p == answer_at) return card_r1;
    return 8'hFF;
  endfunction

  // Byte engine, card and monitor: sample at negedge, drive spi_ready/spi_rx just after posedge.
  initial begin : engine
    logic       st, rdy, cs, drop, prev_start;
    logic [7:0] tx, rx_pend;
    logic [8:0] e;
    int         busy, frame_idx;
    drop = 1'b0; prev_start = 1'b0; rx_pend = 8'hFF; busy = 0; frame_idx = 0;
    forever begin
      @(negedge clk);
      st = spi_start; rdy = spi_ready; cs = cs_n; tx = spi_tx;
      if (cs) frame_idx = 0;
      if (st) begin
        start_cnt++;
        check("start_while_busy", 32'(rdy), 32'd1);
        check("start_single_cycle", 32'(prev_start), 32'd0);
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected: got %0h, expected no byte", {cs, tx});
        end else begin
          e = exp_tx.pop_front();
          check("tx_byte", 32'({cs, tx}), 32'(e));
        end
        rx_pend = card_byte(frame_idx, cs);
        if (!cs) frame_idx++;
        drop = 1'b1;
      end
      prev_start = st;
      if (resp_valid) begin
        resp_cnt++;
        if (exp_resp.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp_unexpected: got r1=%0h to=%0b, expected none", resp_r1, resp_timeout);
        end else begin
          e = exp_resp.pop_front();
          check("resp_r1", 32'(resp_r1), 32'(e[7:0]));
          check("resp_timeout", 32'(resp_timeout), 32'(e[8]));
        end
      end
      if (cmd_valid && cmd_ready) accept_cnt++;
      @(posedge clk);
      #1;
      if (drop) begin
        spi_ready = 1'b0;
        busy = int'($urandom_range(lat_max, lat_min));
        drop = 1'b0;
      end else if (!spi_ready) begin
        if (busy > 1) busy--;
        else begin
          spi_ready = 1'b1;
          spi_rx = rx_pend;
        end
      end
    end
  end

  task automatic push_expect(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc,
                             input int ans, input logic [7:0] r1);
    int  np;
    bit  ok;
    ok = (ans >= 1 && ans <= NcrMax);
    np = ok ? ans : NcrMax;
    for (int i = 0; i < PreBytes; i++) exp_tx.push_back({1'b0, 8'hFF});
    exp_tx.push_back({1'b0, 2'b01, idx});
    exp_tx.push_back({1'b0, arg[31:24]});
    exp_tx.push_back({1'b0, arg[23:16]});
    exp_tx.push_back({1'b0, arg[15:8]});
    exp_tx.push_back({1'b0, arg[7:0]});
    exp_tx.push_back({1'b0, crc});
    for (int i = 0; i < np; i++) exp_tx.push_back({1'b0, 8'hFF});
    exp_tx.push_back({1'b1, 8'hFF});
    exp_resp.push_back(ok ? {1'b0, r1} : {1'b1, 8'hFF});
  endtask

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc,
                       input int ans, input logic [7:0] r1, input bit hold);
    bit got;
    push_expect(idx, arg, crc, ans, r1);
    answer_at = ans;
    card_r1 = r1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1; cmd_idx = idx; cmd_arg = arg;
    if (!hold) begin
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (cmd_ready) begin got = 1'b1; break; end
      end
      check("cmd_accept", 32'(got), 32'd1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_resp(input int target);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (resp_cnt >= target) break;
    end
    @(negedge clk);
    check("resp_arrived", 32'(resp_cnt), 32'(target));
    check("tx_queue_drained", 32'(exp_tx.size()), 32'd0);
  endtask

  initial begin : main
    int  r0, a0, s0;
    bit  found;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_spi_start", 32'(spi_start), 32'd0);
    check("rst_spi_tx", 32'(spi_tx), 32'hFF);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_r1", 32'(resp_r1), 32'hFF);
    check("rst_resp_timeout", 32'(resp_timeout), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(6'd0, 32'h0, 8'h95, 2, 8'h01, 1'b0);           // CMD0
    wait_resp(1);
    issue(6'd8, 32'h0000_01AA, 8'h87, 1, 8'h01, 1'b0);   // CMD8
    wait_resp(2);
    issue(6'd55, 32'h0, 8'h65, 0, 8'h00, 1'b0);          // card silent: timeout
    wait_resp(3);
    check("timeout_r1_holds", 32'(resp_r1), 32'hFF);
    check("timeout_flag_holds", 32'(resp_timeout), 32'd1);
    issue(6'd41, 32'h4000_0000, 8'h77, NcrMax, 8'h00, 1'b0);  // answer on last poll
    wait_resp(4);

    // cmd_valid held through a whole transaction, next command follows resp_valid.
    a0 = accept_cnt; r0 = resp_cnt;
    issue(6'd55, 32'h0, 8'h65, 3, 8'h01, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (resp_valid) begin found = 1'b1; break; end
    end
    check("hold_first_resp", 32'(found), 32'd1);
    push_expect(6'd0, 32'h0, 8'h95, 2, 8'h05);
    answer_at = 2; card_r1 = 8'h05; cmd_idx = 6'd0; cmd_arg = 32'h0;
    @(negedge clk);
    check("hold_ready_after_resp", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    check("hold_accepted_next", 32'(cmd_ready), 32'd0);
    check("hold_cs_low", 32'(cs_n), 32'd0);
    cmd_valid = 1'b0;
    wait_resp(r0 + 2);
    check("hold_accept_count", 32'(accept_cnt - a0), 32'd2);

    // Reset during the third command byte, with the engine left busy across release.
    lat_min = 20; lat_max = 20;
    s0 = start_cnt;
    issue(6'd0, 32'h0, 8'h95, 1, 8'h01, 1'b0);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (start_cnt >= s0 + PreBytes + 3) break;
    end
    #2 rst = 1'b1;
    #1;
    check("abort_cs_n", 32'(cs_n), 32'd1);
    check("abort_spi_start", 32'(spi_start), 32'd0);
    exp_tx.delete();
    exp_resp.delete();
    r0 = resp_cnt;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_engine_busy", 32'(spi_ready), 32'd0);
    lat_min = 2; lat_max = 2;
    issue(6'd0, 32'h0, 8'h95, 2, 8'h01, 1'b0);
    wait_resp(r0 + 1);

    // Variable engine latency.
    lat_min = 2; lat_max = 40;
    r0 = resp_cnt;
    issue(6'd8, 32'h0000_01AA, 8'h87, 3, 8'h01, 1'b0);
    wait_resp(r0 + 1);
    issue(6'd0, 32'h0, 8'h95, 0, 8'h00, 1'b0);
    wait_resp(r0 + 2);
    issue(6'd41, 32'h4000_0000, 8'h77, 1, 8'h00, 1'b0);
    wait_resp(r0 + 3);

    check("resp_queue_drained", 32'(exp_resp.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
